// File: rtl/alu_arbiter.sv
// Purpose: shares one external 64-bit combinational ALU between two requesters with round-robin grant.
// Latency: handshake edge -> one EXEC cycle -> registered response valid from the following cycle.
// Backpressure: RESP holds result until the granted requester takes it; req_ready is low outside IDLE.
//
// Ports:
//   clk, reset                 clock and synchronous active-low reset
//   req_valid/req_ready[1:0]   per-requester request handshake (ready is one-hot or zero)
//   req_a0/req_b0/req_ctrl0    port 0 operands and ALUControl
//   req_a1/req_b1/req_ctrl1    port 1 operands and ALUControl
//   rsp_valid/rsp_ready[1:0]   per-requester response handshake (valid only toward the granted port)
//   rsp_result, rsp_zero       registered ALU result and zero flag
//   alu_a, alu_b, alu_ctrl     to the external ALU (hold last latched values)
//   alu_result, alu_zero       from the external ALU
//   rsp_err                    illegal-opcode flag, present only with ALU_ARB_OPCHECK_EN
//
// Optional feature: define ALU_ARB_OPCHECK_EN to trap ALUControl codes outside
// {0000, 0001, 0010, 0110, 0111}; a trapped op drives alu_ctrl=0000 and returns
// result 0, zero 1, rsp_err 1.
module alu_arbiter #(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req_a0,
  input  logic [WIDTH-1:0]  req_b0,
  input  logic [WIDTH-1:0]  req_a1,
  input  logic [WIDTH-1:0]  req_b1,
  input  logic [CTRL_W-1:0] req_ctrl0,
  input  logic [CTRL_W-1:0] req_ctrl1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero
`ifdef ALU_ARB_OPCHECK_EN
  ,
  output logic              rsp_err
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state;
  logic              prio;      // port that wins a simultaneous request
  logic              grant;     // port owning the transaction in flight
  logic              gnt;       // combinational winner while idle
  logic              hs;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [CTRL_W-1:0] sel_ctrl;

  always_comb begin
    // prio wins if it asks; otherwise the other port (only meaningful if it is valid)
    gnt      = req_valid[prio] ? prio : ~prio;
    sel_a    = gnt ? req_a1 : req_a0;
    sel_b    = gnt ? req_b1 : req_b0;
    sel_ctrl = gnt ? req_ctrl1 : req_ctrl0;

    // Both handshake outputs are gated by reset so nothing is offered while it is asserted.
    req_ready = 2'b00;
    if (reset && (state == ST_IDLE) && (|req_valid))
      req_ready = gnt ? 2'b10 : 2'b01;

    rsp_valid = 2'b00;
    if (reset && (state == ST_RESP))
      rsp_valid = grant ? 2'b10 : 2'b01;
  end

  assign hs = |(req_valid & req_ready);

`ifdef ALU_ARB_OPCHECK_EN
  logic sel_legal;
  logic bad_q;   // latched op was illegal: ALU output is ignored in EXEC

  always_comb begin
    sel_legal = 1'b0;
    case (sel_ctrl)
      CTRL_W'(0), CTRL_W'(1), CTRL_W'(2), CTRL_W'(6), CTRL_W'(7): sel_legal = 1'b1;
      default: sel_legal = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      prio       <= 1'b0;
      grant      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      bad_q      <= 1'b0;
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) begin
            grant <= gnt;
            alu_a <= sel_a;
            alu_b <= sel_b;
`ifdef ALU_ARB_OPCHECK_EN
            alu_ctrl <= sel_legal ? sel_ctrl : '0;
            bad_q    <= ~sel_legal;
`else
            alu_ctrl <= sel_ctrl;
`endif
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
`ifdef ALU_ARB_OPCHECK_EN
          rsp_result <= bad_q ? '0 : alu_result;
          rsp_zero   <= bad_q ? 1'b1 : alu_zero;
          rsp_err    <= bad_q;
`else
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
`endif
          state <= ST_RESP;
        end
        ST_RESP: begin
          // rsp_ready on the non-granted port is deliberately ignored
          if (rsp_ready[grant]) begin
            prio  <= ~grant;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: supplies the external ALU, runs directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a transaction-level model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_ctrl0, req_ctrl1;
  logic [63:0] rsp_result, alu_a, alu_b, alu_result;
  logic        rsp_zero, alu_zero;
  logic [3:0]  alu_ctrl;
  logic        rsp_err_s;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef ALU_ARB_OPCHECK_EN
    , .rsp_err(rsp_err_s)
`endif
  );

`ifndef ALU_ARB_OPCHECK_EN
  assign rsp_err_s = 1'b0;
`endif

  // External ALU: AND, OR, ADD, SUB, pass-b; anything else XOR.
  function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
    case (c)
      4'b0000: alu_fn = a & b;
      4'b0001: alu_fn = a | b;
      4'b0010: alu_fn = a + b;
      4'b0110: alu_fn = a - b;
      4'b0111: alu_fn = b;
      default: alu_fn = a ^ b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == 64'd0);

  function automatic bit op_legal(input logic [3:0] c);
`ifdef ALU_ARB_OPCHECK_EN
    op_legal = c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
`else
    op_legal = 1'b1;
`endif
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One outstanding transaction at most; the response is offered from the second
  // cycle after acceptance and retires when the owner takes it.
  bit          m_busy = 0, m_port = 0, m_prio = 0;
  int          m_age = 0;
  logic [63:0] m_a = 0, m_b = 0, m_res = 0, p_res = 0;
  logic [3:0]  m_ctrl = 0;
  bit          m_zero = 0, m_err = 0, p_zero = 0, p_err = 0;

  initial begin
    logic [1:0] exp_rdy, exp_rv;
    bit w;
    logic [63:0] a, b;
    logic [3:0] c;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_rdy = 2'b00;
      exp_rv  = 2'b00;
      w = req_valid[m_prio] ? m_prio : !m_prio;
      if (reset) begin
        if (!m_busy && (|req_valid)) exp_rdy[w] = 1'b1;
        if (m_busy && m_age >= 1) exp_rv[m_port] = 1'b1;
      end
      check("req_ready", req_ready, exp_rdy);
      check("rsp_valid", rsp_valid, exp_rv);
      check("rsp_result", rsp_result, m_res);
      check("rsp_zero", rsp_zero, m_zero);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_ctrl", alu_ctrl, m_ctrl);
`ifdef ALU_ARB_OPCHECK_EN
      check("rsp_err", rsp_err_s, m_err);
`endif
      // advance model to the state after the coming posedge
      if (!reset) begin
        m_busy = 0; m_prio = 0; m_age = 0;
        m_a = 0; m_b = 0; m_ctrl = 0; m_res = 0; m_zero = 0; m_err = 0;
      end else if (!m_busy) begin
        if (|req_valid) begin
          a = w ? req_a1 : req_a0;
          b = w ? req_b1 : req_b0;
          c = w ? req_ctrl1 : req_ctrl0;
          m_busy = 1; m_port = w; m_age = 0;
          m_a = a; m_b = b;
          if (op_legal(c)) begin
            m_ctrl = c; p_res = alu_fn(a, b, c); p_zero = (p_res == 0); p_err = 0;
          end else begin
            m_ctrl = 4'b0000; p_res = 0; p_zero = 1; p_err = 1;
          end
        end
      end else if (m_age == 0) begin
        m_res = p_res; m_zero = p_zero; m_err = p_err; m_age = 1;
      end else if (rsp_ready[m_port]) begin
        m_busy = 0; m_prio = !m_port;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // From posedge+1: returns at the negedge where rsp_valid[p] is seen (bounded).
  task automatic wait_rsp(input int p, input string nm);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid[p] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_rsp_seen"}, rsp_valid[p], 1'b1);
  endtask

  // Single request on port p (rsp_ready must be 1); returns at its response negedge.
  task automatic do_op(input int p, input logic [63:0] a, input logic [63:0] b, input logic [3:0] c, input string nm);
    int n = 0;
    if (p == 0) begin req_a0 = a; req_b0 = b; req_ctrl0 = c; end
    else        begin req_a1 = a; req_b1 = b; req_ctrl1 = c; end
    req_valid = (p == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    while (!req_ready[p] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_accept"}, req_ready[p], 1'b1);
    tick;
    req_valid = 2'b00;
    wait_rsp(p, nm);
  endtask

  initial begin
    logic [3:0] legal_ops [5];
    logic [63:0] held;
    legal_ops[0] = 4'b0000; legal_ops[1] = 4'b0001; legal_ops[2] = 4'b0010;
    legal_ops[3] = 4'b0110; legal_ops[4] = 4'b0111;

    // 1: reset held with both requesting
    reset = 0; req_valid = 2'b11; rsp_ready = 2'b11;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0; req_ctrl0 = 0; req_ctrl1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_req_ready", req_ready, 2'b00);
    check("t1_rsp_valid", rsp_valid, 2'b00);
    check("t1_rsp_result", rsp_result, 64'd0);

    // 2: port 0 alone, AND; response two cycles after request is presented
    tick;
    reset = 1; req_valid = 2'b01;
    req_a0 = 64'd93846573825364758; req_b0 = 64'd27313240968594; req_ctrl0 = 4'b0000;
    @(negedge clk);
    check("t2_req_ready", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    @(negedge clk);
    check("t2_exec_no_valid", rsp_valid, 2'b00);
    tick;
    @(negedge clk);
    check("t2_rsp_valid", rsp_valid, 2'b01);
    check("t2_result", rsp_result, 64'd9715484885266);
    check("t2_zero", rsp_zero, 1'b0);

    // 3: both valid straight out of reset
    tick;
    reset = 0; req_valid = 2'b11;
    req_a0 = 64'd2; req_b0 = 64'd9223372036854775807; req_ctrl0 = 4'b0010;
    req_a1 = 64'd27586970463758451; req_b1 = 64'd27586970463758451; req_ctrl1 = 4'b0110;
    tick;
    reset = 1;
    @(negedge clk);
    check("t3_first_grant", req_ready, 2'b01);
    tick;
    req_valid = 2'b10;
    wait_rsp(0, "t3p0");
    check("t3_p0_result", rsp_result, 64'd9223372036854775809);
    wait_rsp(1, "t3p1");
    check("t3_p1_rsp_valid", rsp_valid, 2'b10);
    check("t3_p1_result", rsp_result, 64'd0);
    check("t3_p1_zero", rsp_zero, 1'b1);
    tick;
    req_valid = 2'b00;

    // 4: backpressure with both ports waiting
    tick;
    rsp_ready = 2'b00; req_valid = 2'b11;
    req_a0 = 64'd5; req_b0 = 64'd7; req_ctrl0 = 4'b0010;
    req_a1 = 64'hF0; req_b1 = 64'h0F; req_ctrl1 = 4'b0001;
    wait_rsp(0, "t4p0");
    held = rsp_result;
    check("t4_result", held, 64'd12);
    for (int i = 0; i < 5; i++) begin
      tick;
      @(negedge clk);
      check("t4_hold_result", rsp_result, 64'd12);
      check("t4_hold_ready", req_ready, 2'b00);
      check("t4_hold_valid", rsp_valid, 2'b01);
    end
    tick;
    rsp_ready = 2'b01;
    @(negedge clk);
    check("t4_released", rsp_valid, 2'b01);
    tick;
    @(negedge clk);
    check("t4_next_grant", req_ready, 2'b10);
    tick;
    req_valid = 2'b00; rsp_ready = 2'b11;
    wait_rsp(1, "t4p1");
    check("t4_p1_result", rsp_result, 64'hFF);

    // 5: reset during EXEC; prio is first steered to port 1
    tick;
    do_op(0, 64'd1, 64'd1, 4'b0010, "t5pre");
    tick;
    do_op(1, 64'd3, 64'd4, 4'b0010, "t5pre1");
    tick;
    do_op(0, 64'd8, 64'd9, 4'b0001, "t5pre2");
    tick;
    req_a1 = 64'd100; req_b1 = 64'd1; req_ctrl1 = 4'b0110; req_valid = 2'b10;
    @(negedge clk);
    check("t5_accept", req_ready, 2'b10);
    tick;
    req_valid = 2'b00; reset = 0;
    tick;
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_rsp", rsp_valid, 2'b00);
      tick;
    end
    req_valid = 2'b11;
    @(negedge clk);
    check("t5_grant0", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    wait_rsp(0, "t5p0");

    // 6: opcode check / pass-through
    tick;
`ifdef ALU_ARB_OPCHECK_EN
    do_op(0, 64'd5, 64'd9, 4'b1111, "t6bad");
    check("t6_err", rsp_err_s, 1'b1);
    check("t6_result", rsp_result, 64'd0);
    check("t6_zero", rsp_zero, 1'b1);
    tick;
    do_op(1, 64'd5, 64'd9, 4'b0010, "t6ok");
    check("t6_ok_err", rsp_err_s, 1'b0);
    check("t6_ok_result", rsp_result, 64'd14);
`else
    do_op(0, 64'd123, 64'd27313240968594, 4'b0111, "t6");
    check("t6_result", rsp_result, 64'd27313240968594);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick;
      reset     = ($urandom_range(0, 199) != 0);
      req_valid = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
      req_a0 = {$urandom, $urandom};
      req_b0 = ($urandom_range(0, 5) == 0) ? req_a0 : {$urandom, $urandom};
      req_a1 = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      req_b1 = ($urandom_range(0, 5) == 0) ? req_a1 : {$urandom, $urandom};
      req_ctrl0 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 4)];
      req_ctrl1 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 4)];
    end
    tick;
    reset = 1; req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (5) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
